// File: rtl/mouse_analog_emu.sv
// ---------------------------------------------------------------------------
// mouse_analog_emu
//
// Analog-stick source stage feeding the core's JOY1X/JOY1Y/JOY1 inputs.
// It passes the HPS analog stick through until a PS/2 mouse packet arrives.
// From then on it integrates the mouse deltas into a saturating signed 8-bit
// position and maps the mouse buttons onto the fire bits. It hands control
// back to the stick as soon as the stick moves or the CPU halts. While the
// mouse owns the outputs, an optional auto-recentre slowly pulls the
// position back to the origin.
//
// Parameters
//   SHIFT      arithmetic right shift applied to each raw 9-bit mouse delta
//   MAX_STEP   per-packet delta clamp magnitude, applied after the shift
//   DECAY_DIV  clk_sys cycles per recentre step (>= 2)
//   INVERT_Y   1 = negate the Y delta before accumulation
//
// Ports
//   clk_sys       system clock
//   reset         asynchronous, active-high reset
//   ps2_mouse     [24] strobe toggle, [23:16] Y, [15:8] X, [5] Y sign,
//                 [4] X sign, [1:0] buttons
//   joya          analog stick, [7:0] X, [15:8] Y, two's complement
//   joy           digital joystick word, [3:0] directions, [5:4] fire
//   cpu_halt      core halted; hands control back to the stick
//   recentre_en   enables auto-recentre while in mouse mode
//   ax, ay        registered X/Y position to the core
//   joy_out       registered button/direction word to the core
//   mouse_active  1 while the mouse owns the outputs
// ---------------------------------------------------------------------------
module mouse_analog_emu #(
  parameter int SHIFT     = 1,
  parameter int MAX_STEP  = 10,
  parameter int DECAY_DIV = 65536,
  parameter int INVERT_Y  = 0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  input  logic [15:0] joya,
  input  logic [15:0] joy,
  input  logic        cpu_halt,
  input  logic        recentre_en,
  output logic [7:0]  ax,
  output logic [7:0]  ay,
  output logic [15:0] joy_out,
  output logic        mouse_active
);

  localparam int                CNT_W    = $clog2(DECAY_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECAY_DIV - 1);
  localparam logic signed [10:0] STEP_HI = 11'(MAX_STEP);
  localparam logic signed [10:0] STEP_LO = 11'(-MAX_STEP);

  typedef enum logic {
    ST_JOY   = 1'b0,
    ST_MOUSE = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic signed [7:0] mx;
  logic signed [7:0] my;
  logic [CNT_W-1:0]  decay_cnt;
  logic              stb_d;
  logic              primed;
  logic              strobe_event;
  logic              stick_busy;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic [7:0]        ax_d;
  logic [7:0]        ay_d;
  logic [15:0]       joy_d;
  logic              active_d;
  logic              unused_pkt_bits;

  // Raw 9-bit delta -> shifted, optionally negated, clamped step.
  // 11 bits leave room for negating -256 without overflow.
  function automatic logic signed [10:0] axis_delta(input logic       sgn,
                                                    input logic [7:0] mag,
                                                    input logic       negate);
    logic signed [10:0] d;
    d = $signed({{3{sgn}}, mag});
    d = d >>> SHIFT;
    if (negate) d = -d;
    if (d > STEP_HI) d = STEP_HI;
    else if (d < STEP_LO) d = STEP_LO;
    return d;
  endfunction

  // Saturating accumulate; the position pins at the rails and never wraps.
  function automatic logic signed [7:0] sat_add(input logic signed [7:0]  acc,
                                                input logic signed [10:0] d);
    logic signed [11:0] sum;
    sum = $signed({{4{acc[7]}}, acc}) + $signed({d[10], d});
    if (sum > 12'sd127) return 8'sh7F;
    if (sum < -12'sd128) return 8'sh80;
    return sum[7:0];
  endfunction

  // One recentre step: move a nonzero axis one count toward the origin.
  function automatic logic signed [7:0] toward_zero(input logic signed [7:0] v);
    if (v == 8'sd0) return v;
    if (v[7]) return v + 8'sd1;
    return v - 8'sd1;
  endfunction

  // Status and padding bits of the packet carry nothing for this stage.
  assign unused_pkt_bits = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

  assign stick_busy   = (joya != 16'h0000) || cpu_halt;
  assign strobe_event = primed && (ps2_mouse[24] != stb_d);
  assign dx = axis_delta(ps2_mouse[4], ps2_mouse[15:8], 1'b0);
  assign dy = axis_delta(ps2_mouse[5], ps2_mouse[23:16], (INVERT_Y != 0));

  // Strobe edge detector. The first edge after reset only captures the
  // current toggle level, so a stale level left over from before reset is
  // never mistaken for a new packet.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      stb_d  <= 1'b0;
      primed <= 1'b0;
    end else begin
      stb_d  <= ps2_mouse[24];
      primed <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= ST_JOY;
    else       state_q <= state_d;
  end

  // Next-state logic. Stick movement or a halted CPU always wins over a
  // mouse packet arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_JOY:   if (strobe_event && !stick_busy) state_d = ST_MOUSE;
      ST_MOUSE: if (stick_busy)                  state_d = ST_JOY;
      default:  state_d = ST_JOY;
    endcase
  end

  // Position accumulator and recentre divider. The accumulator is always
  // zero in stick mode, so the packet that switches into mouse mode simply
  // lands on the origin. Any packet restarts the recentre interval.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mx        <= 8'sd0;
      my        <= 8'sd0;
      decay_cnt <= '0;
    end else if (stick_busy) begin
      mx        <= 8'sd0;
      my        <= 8'sd0;
      decay_cnt <= '0;
    end else if (strobe_event) begin
      mx        <= sat_add(mx, dx);
      my        <= sat_add(my, dy);
      decay_cnt <= '0;
    end else if (state_q == ST_MOUSE && recentre_en) begin
      if (decay_cnt == CNT_LAST) begin
        decay_cnt <= '0;
        mx        <= toward_zero(mx);
        my        <= toward_zero(my);
      end else begin
        decay_cnt <= decay_cnt + 1'b1;
      end
    end else begin
      decay_cnt <= '0;
    end
  end

  // Output selection. joya == FFFF means no analog device is attached;
  // the directions are then masked so a floating stick cannot steer.
  always_comb begin
    ax_d     = joya[7:0];
    ay_d     = joya[15:8];
    joy_d    = joy;
    active_d = 1'b0;
    if (state_q == ST_MOUSE) begin
      ax_d     = mx;
      ay_d     = my;
      joy_d    = {joy[15:6], ps2_mouse[1:0], joy[3:0]};
      active_d = 1'b1;
    end
    if (joya == 16'hFFFF) joy_d[3:0] = 4'h0;
  end

  // Output register: the core sees every change one cycle after the
  // state/position update.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ax           <= 8'h00;
      ay           <= 8'h00;
      joy_out      <= 16'h0000;
      mouse_active <= 1'b0;
    end else begin
      ax           <= ax_d;
      ay           <= ay_d;
      joy_out      <= joy_d;
      mouse_active <= active_d;
    end
  end

endmodule

// File: tb/tb_mouse_analog_emu.sv
// ---------------------------------------------------------------------------
// tb_mouse_analog_emu
//
// Bench for mouse_analog_emu. Two instances run side by side on the same
// stimulus: one with a short recentre period and the default delta path,
// one with no shift, a wide clamp, a 3-cycle recentre and inverted Y.
// A behavioural model tracks both every cycle; table vectors and a few
// hand-written sequences additionally check instance A against fixed values.
// ---------------------------------------------------------------------------
module tb_mouse_analog_emu;

  localparam int SHIFT_A = 1;
  localparam int MAX_A   = 10;
  localparam int DIV_A   = 4;
  localparam int INV_A   = 0;
  localparam int SHIFT_B = 0;
  localparam int MAX_B   = 100;
  localparam int DIV_B   = 3;
  localparam int INV_B   = 1;

  logic        clk_sys;
  logic        reset;
  logic [24:0] ps2_mouse;
  logic [15:0] joya;
  logic [15:0] joy;
  logic        cpu_halt;
  logic        recentre_en;
  logic [7:0]  ax_o [2];
  logic [7:0]  ay_o [2];
  logic [15:0] jo_o [2];
  logic        act_o [2];

  // Behavioural model state, one slot per instance.
  int          m_x [2];
  int          m_y [2];
  int          m_tick [2];
  bit          m_mouse [2];
  bit          m_primed [2];
  bit          m_stb [2];
  logic [7:0]  e_ax [2];
  logic [7:0]  e_ay [2];
  logic [15:0] e_jo [2];
  logic        e_act [2];

  int n_checks;
  int n_fail;

  typedef struct {
    bit          tog;
    logic [7:0]  xb;
    bit          xs;
    logic [7:0]  yb;
    bit          ys;
    logic [1:0]  btn;
    logic [15:0] ja;
    logic [15:0] jy;
    bit          halt;
    logic [7:0]  x_ax;
    logic [7:0]  x_ay;
    bit          x_act;
    logic [15:0] x_jo;
  } vec_t;

  vec_t vecs [10];

  mouse_analog_emu #(.SHIFT(SHIFT_A), .MAX_STEP(MAX_A), .DECAY_DIV(DIV_A), .INVERT_Y(INV_A)) dut_a (
    .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse), .joya(joya), .joy(joy),
    .cpu_halt(cpu_halt), .recentre_en(recentre_en),
    .ax(ax_o[0]), .ay(ay_o[0]), .joy_out(jo_o[0]), .mouse_active(act_o[0]));

  mouse_analog_emu #(.SHIFT(SHIFT_B), .MAX_STEP(MAX_B), .DECAY_DIV(DIV_B), .INVERT_Y(INV_B)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse), .joya(joya), .joy(joy),
    .cpu_halt(cpu_halt), .recentre_en(recentre_en),
    .ax(ax_o[1]), .ay(ay_o[1]), .joy_out(jo_o[1]), .mouse_active(act_o[1]));

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  function automatic int p_shift(input int k); return (k == 0) ? SHIFT_A : SHIFT_B; endfunction
  function automatic int p_max(input int k);   return (k == 0) ? MAX_A   : MAX_B;   endfunction
  function automatic int p_div(input int k);   return (k == 0) ? DIV_A   : DIV_B;   endfunction
  function automatic int p_inv(input int k);   return (k == 0) ? INV_A   : INV_B;   endfunction

  // Signed mouse delta as an integer: floor division by 2^SHIFT,
  // optional negation, then clamp.
  function automatic int delta_of(input logic [7:0] b, input logic s, input int k, input bit is_y);
    int raw;
    int div;
    int d;
    raw = s ? int'(b) - 256 : int'(b);
    div = 1 << p_shift(k);
    d = (raw >= 0) ? raw / div : -((-raw + div - 1) / div);
    if (is_y && p_inv(k) != 0) d = -d;
    if (d > p_max(k)) d = p_max(k);
    if (d < -p_max(k)) d = -p_max(k);
    return d;
  endfunction

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int pull_in(input int v);
    if (v > 0) return v - 1;
    if (v < 0) return v + 1;
    return 0;
  endfunction

  task automatic model_step(input int k);
    bit busy;
    bit ev;
    int dx;
    int dy;
    logic [15:0] jw;
    if (reset) begin
      m_x[k] = 0; m_y[k] = 0; m_tick[k] = 0;
      m_mouse[k] = 0; m_primed[k] = 0; m_stb[k] = 0;
      e_ax[k] = 8'h00; e_ay[k] = 8'h00; e_jo[k] = 16'h0000; e_act[k] = 1'b0;
      return;
    end
    busy = (joya != 16'h0000) || cpu_halt;
    ev   = m_primed[k] && (ps2_mouse[24] != m_stb[k]);
    e_ax[k]  = m_mouse[k] ? 8'(m_x[k]) : joya[7:0];
    e_ay[k]  = m_mouse[k] ? 8'(m_y[k]) : joya[15:8];
    jw = joy;
    if (m_mouse[k]) jw[5:4] = ps2_mouse[1:0];
    if (joya == 16'hFFFF) jw[3:0] = 4'h0;
    e_jo[k]  = jw;
    e_act[k] = m_mouse[k];
    dx = delta_of(ps2_mouse[15:8], ps2_mouse[4], k, 1'b0);
    dy = delta_of(ps2_mouse[23:16], ps2_mouse[5], k, 1'b1);
    if (m_mouse[k] && busy) begin
      m_mouse[k] = 0; m_x[k] = 0; m_y[k] = 0; m_tick[k] = 0;
    end else if (ev && !busy) begin
      m_mouse[k] = 1;
      m_x[k] = sat8(m_x[k] + dx);
      m_y[k] = sat8(m_y[k] + dy);
      m_tick[k] = 0;
    end else if (m_mouse[k] && recentre_en) begin
      if (m_tick[k] == p_div(k) - 1) begin
        m_tick[k] = 0;
        m_x[k] = pull_in(m_x[k]);
        m_y[k] = pull_in(m_y[k]);
      end else begin
        m_tick[k] = m_tick[k] + 1;
      end
    end else begin
      m_tick[k] = 0;
    end
    m_primed[k] = 1;
    m_stb[k] = ps2_mouse[24];
  endtask

  // The model advances on the same edge as the design.
  always @(posedge clk_sys) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic checkValue(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      checkValue($sformatf("model_ax_%0d", k), ax_o[k], e_ax[k]);
      checkValue($sformatf("model_ay_%0d", k), ay_o[k], e_ay[k]);
      checkValue($sformatf("model_joy_out_%0d", k), jo_o[k], e_jo[k]);
      checkValue($sformatf("model_active_%0d", k), act_o[k], e_act[k]);
    end
  endtask

  // Advance to the next falling edge and compare both instances to the model.
  task automatic tick();
    @(negedge clk_sys);
    checkOutput();
  endtask

  task automatic applyStimulus(input bit tog, input logic [7:0] xb, input bit xs,
                               input logic [7:0] yb, input bit ys, input logic [1:0] btn,
                               input logic [15:0] ja, input logic [15:0] jy,
                               input bit halt, input bit rec);
    ps2_mouse[24]    = ps2_mouse[24] ^ tog;
    ps2_mouse[23:16] = yb;
    ps2_mouse[15:8]  = xb;
    ps2_mouse[7:6]   = 2'($urandom);
    ps2_mouse[5]     = ys;
    ps2_mouse[4]     = xs;
    ps2_mouse[3:2]   = 2'($urandom);
    ps2_mouse[1:0]   = btn;
    joya        = ja;
    joy         = jy;
    cpu_halt    = halt;
    recentre_en = rec;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic checkA(input string name, input logic [7:0] x_ax, input logic [7:0] x_ay, input bit x_act);
    checkValue({name, "_ax"}, ax_o[0], x_ax);
    checkValue({name, "_ay"}, ay_o[0], x_ay);
    checkValue({name, "_active"}, act_o[0], x_act);
  endtask

  initial begin
    int exp_x;
    int exp_y;
    int r;
    bit tog;
    bit halt;
    bit rec;
    logic [15:0] ja;

    n_checks = 0;
    n_fail   = 0;
    reset       = 1'b1;
    ps2_mouse   = 25'h1000000;
    joya        = 16'h0000;
    joy         = 16'h0000;
    cpu_halt    = 1'b0;
    recentre_en = 1'b0;

    // tog, X, Xs, Y, Ys, btn, joya, joy, halt -> ax, ay, active, joy_out
    vecs[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h0A, 8'h00, 1'b1, 16'h0000};
    vecs[2] = '{1'b1, 8'h06, 1'b0, 8'hF0, 1'b1, 2'b10, 16'h0000, 16'h00C3, 1'b0, 8'h0D, 8'hF8, 1'b1, 16'h00E3};
    vecs[3] = '{1'b1, 8'hFF, 1'b1, 8'h01, 1'b0, 2'b01, 16'h0000, 16'h0000, 1'b0, 8'h0C, 8'hF8, 1'b1, 16'h0010};
    vecs[4] = '{1'b1, 8'h00, 1'b1, 8'hFF, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h02, 8'h02, 1'b1, 16'h0000};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b00, 16'h1234, 16'h5A5A, 1'b0, 8'h34, 8'h12, 1'b0, 16'h5A5A};
    vecs[6] = '{1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 2'b00, 16'h1234, 16'h5A5A, 1'b0, 8'h34, 8'h12, 1'b0, 16'h5A5A};
    vecs[7] = '{1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 2'b11, 16'h0000, 16'h000F, 1'b1, 8'h00, 8'h00, 1'b0, 16'h000F};
    vecs[8] = '{1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 2'b11, 16'hFFFF, 16'h003F, 1'b0, 8'hFF, 8'hFF, 1'b0, 16'h0030};
    vecs[9] = '{1'b1, 8'h08, 1'b0, 8'h08, 1'b1, 2'b11, 16'h0000, 16'hFFFF, 1'b0, 8'h04, 8'hF6, 1'b1, 16'hFFFF};

    // Reset with the strobe already high; outputs must be cleared.
    tick();
    tick();
    checkA("reset", 8'h00, 8'h00, 1'b0);
    checkValue("reset_joy_out", jo_o[0], 16'h0000);
    reset = 1'b0;
    tick();

    // Table vectors, each held for two cycles.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].tog, vecs[i].xb, vecs[i].xs, vecs[i].yb, vecs[i].ys, vecs[i].btn,
                    vecs[i].ja, vecs[i].jy, vecs[i].halt, 1'b0);
      tick();
      tick();
      checkA($sformatf("vec%0d", i), vecs[i].x_ax, vecs[i].x_ay, vecs[i].x_act);
      checkValue($sformatf("vec%0d_joy_out", i), jo_o[0], vecs[i].x_jo);
    end

    // Saturation at both rails.
    doReset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tick();
    end
    tick();
    checkA("sat_pos", 8'h7F, 8'h00, 1'b1);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 8'hEC, 1'b1, 8'h00, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tick();
    end
    tick();
    checkA("sat_neg", 8'h80, 8'h00, 1'b1);

    // Stick movement in the same cycle as a packet: stick wins, acc cleared.
    doReset();
    applyStimulus(1'b1, 8'h0A, 1'b0, 8'h00, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    checkA("prio_setup", 8'h05, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h0A, 1'b0, 8'h00, 1'b0, 2'b00, 16'h0030, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    checkA("prio_stick", 8'h30, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    checkA("prio_acc_cleared", 8'h01, 8'h00, 1'b1);

    // Recentre from (3,-2) with no further packets.
    doReset();
    applyStimulus(1'b1, 8'h06, 1'b0, 8'hFC, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);
    tick();
    for (int k = 1; k <= 18; k++) begin
      tick();
      exp_x = 3 - (k - 1) / DIV_A;
      if (exp_x < 0) exp_x = 0;
      exp_y = -2 + (k - 1) / DIV_A;
      if (exp_y > 0) exp_y = 0;
      checkA($sformatf("recentre_k%0d", k), 8'(exp_x), 8'(exp_y), 1'b1);
    end

    // Reset mid-packet: the pending toggle must not count as an event.
    applyStimulus(1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    checkA("midreset_idle", 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    checkA("midreset_first_event", 8'h0A, 8'h00, 1'b1);

    // Randomized run against the model: busy packets first, then sparse
    // packets so recentre gets long quiet stretches.
    rec = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
      end
      tog = (c < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      r = int'($urandom_range(0, 99));
      if (r < 96)      ja = 16'h0000;
      else if (r < 98) ja = 16'($urandom);
      else             ja = 16'hFFFF;
      halt = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 63) == 0) rec = ~rec;
      applyStimulus(tog, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 2'($urandom),
                    ja, 16'($urandom), halt, rec);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mouse_analog_emu.md
Name: mouse_analog_emu

Overview:
- Analog-stick source stage that sits directly upstream of the console core's JOY1X/JOY1Y/JOY1 inputs.
- Arbitrates between the HPS analog joystick and a PS/2 mouse.
- In mouse mode, integrates mouse deltas into a saturating 8-bit signed position, with optional auto-recentre.
- Remaps mouse buttons onto the fire bits. Returns control to the stick when the stick moves or the CPU halts.

Parameters:
- SHIFT, 1: arithmetic right-shift applied to each raw 9-bit mouse delta.
- MAX_STEP, 10: per-packet delta clamp magnitude, after the shift.
- DECAY_DIV, 65536: clk_sys cycles per recentre step; must be ≥ 2.
- INVERT_Y, 0: 1 means the Y delta is negated before accumulation.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ps2_mouse  in  25  HPS mouse packet: [24] strobe toggle, [15:8] X, [23:16] Y, [4] X sign, [5] Y sign, [1:0] buttons
- joya  in  16  analog stick: [7:0] X, [15:8] Y, two's complement
- joy  in  16  digital joystick/buttons; [3:0] directions, [5:4] fire
- cpu_halt  in  1  core halted; forces stick mode
- recentre_en  in  1  enables auto-recentre in mouse mode
- ax  out  8  X position to core
- ay  out  8  Y position to core
- joy_out  out  16  button/direction word to core
- mouse_active  out  1  1 while in MOUSE state

Behaviour:
- Reset (async, active-high) sets:
  - state JOY; mx = my = 0; ax = ay = 0; joy_out = 0; mouse_active = 0.
  - decay counter 0; primed = 0.
- Strobe detect:
  - stb_d registers ps2_mouse[24] every cycle.
  - On the first clock after reset release (primed = 0), the block only samples and sets primed = 1; no event is generated.
  - Thereafter, event = (ps2_mouse[24] != stb_d), evaluated at the same edge.
- Delta path, per axis:
  - d9 = {sign, byte}, sign-extended to 10 bits, then arithmetic shift right by SHIFT.
  - If INVERT_Y = 1, negate the Y delta.
  - Clamp to [-MAX_STEP, +MAX_STEP].
  - n = acc + d. Acc saturates to [-128, +127]; it never wraps.
- State machine:
  - JOY: an event moves to MOUSE and applies the event's deltas to acc (0,0) in the same edge.
  - MOUSE: each event updates acc.
  - MOUSE → JOY when (joya != 0) or cpu_halt; mx = my = 0 and the decay counter is cleared.
  - The stick/halt condition has priority over an event in the same cycle: the result is state JOY with acc 0.
  - In JOY state with joya != 0 or cpu_halt, events are ignored.
- Recentre (MOUSE state with recentre_en = 1):
  - The decay counter increments each cycle and clears on any event.
  - When the counter reaches DECAY_DIV-1, it wraps to 0 and each nonzero axis moves 1 toward 0.
  - An axis at 0 stays at 0.
  - With recentre_en = 0, the counter is held at 0.
- Outputs are registered, one cycle after state/acc update:
  - ax = MOUSE ? mx[7:0] : joya[7:0]; ay likewise with my and joya[15:8].
  - joy_out = MOUSE ? {joy[15:6], ps2_mouse[1:0], joy[3:0]} : joy.
  - Then joy_out[3:0] is forced to 0 when joya == 16'hFFFF (no analog device attached).
  - mouse_active = (state == MOUSE).
- Latency: a strobe toggle sampled at edge N changes acc at N; ax/ay reflect it after edge N+1.
- Reset asserted mid-packet: all state is cleared; the next toggle after re-priming is the first event.

Test Plan:
- Reset with ps2_mouse[24] = 1, release, hold inputs → no event, mouse_active = 0, ax = ay = 0.
- joya = 0, toggle strobe with X = 8'h14, sign 0 (+20) → d = +10 after shift, clamped to 10; mouse_active = 1; ax = 8'h0A two cycles after the toggle.
- 14 toggles of X = +20 from 0 → ax saturates at 8'h7F. Then 30 toggles of X = 8'hEC with sign 1 → ax saturates at 8'h80, no wrap.
- In MOUSE with mx = 5, apply joya = 16'h0030 in the same cycle as a strobe toggle → state JOY, ax = 8'h30, acc = 0, mouse_active = 0.
- recentre_en = 1, DECAY_DIV = 4, mx = 3, my = -2, no events → after 4/8/12 cycles ax = 2/1/0 and ay = -1/0/0; stays 0 afterwards.
- MOUSE state with ps2_mouse[1:0] = 2'b10, joy = 16'h0000 → joy_out[5:4] = 2'b10. With joya = 16'hFFFF (cpu_halt low, stick released), joy[3:0] = 4'hF → joy_out[3:0] = 0. Assert cpu_halt → JOY state.
